// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit multicycle processor: opcodes, function codes,
// ALU operations, mux selects, controller states and the registered strobe bundle.
package proc_pkg;

    localparam logic [3:0] OP_FUNC  = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BE    = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_ORI   = 4'b0110;
    localparam logic [3:0] OP_NANDI = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_ADDUI = 4'b1010;
    localparam logic [3:0] OP_NAND  = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_SUBUI = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1111;

    localparam logic [3:0] FN_SHL = 4'b0001;
    localparam logic [3:0] FN_SHR = 4'b0010;
    localparam logic [3:0] FN_SAR = 4'b0011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SHL  = 4'b0010;
    localparam logic [3:0] ALU_SHR  = 4'b0011;
    localparam logic [3:0] ALU_SAR  = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_OFF = 2'b11;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_sel;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// datapath strobes out. master = controller, slave = datapath.
interface multicycle_control_if;

    logic [3:0] OPCODE;
    logic [3:0] FUNCFIELD;
    logic       mem_ready;
    logic       C_IRWrite;
    logic       C_PCWrite;
    logic       C_PCWriteCond;
    logic       C_BranchNe;
    logic [1:0] C_PCSrc;
    logic       C_IorD;
    logic       C_MemRead;
    logic       C_MemWrite;
    logic       C_RegWrite;
    logic       C_MemtoReg;
    logic       C_ALUSrcA;
    logic [1:0] C_ALUSrcB;
    logic       C_ExtSel;
    logic [3:0] C_ALUOp;
    logic       C_Illegal;

    modport master (
        input  OPCODE, FUNCFIELD, mem_ready,
        output C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNe, C_PCSrc, C_IorD,
               C_MemRead, C_MemWrite, C_RegWrite, C_MemtoReg, C_ALUSrcA, C_ALUSrcB,
               C_ExtSel, C_ALUOp, C_Illegal
    );

    modport slave (
        output OPCODE, FUNCFIELD, mem_ready,
        input  C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNe, C_PCSrc, C_IorD,
               C_MemRead, C_MemWrite, C_RegWrite, C_MemtoReg, C_ALUSrcA, C_ALUSrcB,
               C_ExtSel, C_ALUOp, C_Illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational map from OPCODE/FUNCFIELD to ALU operation, immediate extension
// mode and an undefined-function flag.
module alu_op_decode
    import proc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] funcfield,
    output logic [3:0] alu_op,
    output logic       ext_sel,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        unique case (opcode)
            OP_FUNC: begin
                unique case (funcfield)
                    FN_SHL:  alu_op = ALU_SHL;
                    FN_SHR:  alu_op = ALU_SHR;
                    FN_SAR:  alu_op = ALU_SAR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_SUB, OP_SUBI, OP_SUBUI, OP_BE, OP_BNE: alu_op = ALU_SUB;
            OP_NAND, OP_NANDI:                        alu_op = ALU_NAND;
            OP_OR, OP_ORI:                            alu_op = ALU_OR;
            default:                                  alu_op = ALU_ADD;
        endcase
    end

    // Only the signed immediate forms sign-extend; address calc forces it separately.
    assign ext_sel = (opcode == OP_ADDI) || (opcode == OP_SUBI);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: fetch/decode/execute/memory/write-back FSM driving all
// datapath strobes as registered Moore outputs.
module multicycle_control
    import proc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_e     state;
    state_e     nxt;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic       illegal_q;
    logic [3:0] dec_alu_op;
    logic       dec_ext_sel;
    logic       dec_illegal;

    alu_op_decode u_alu_op_decode (
        .opcode   (bus.OPCODE),
        .funcfield(bus.FUNCFIELD),
        .alu_op   (dec_alu_op),
        .ext_sel  (dec_ext_sel),
        .illegal  (dec_illegal)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_RST:    nxt = S_FETCH;
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.OPCODE)
                    OP_FUNC:                      nxt = dec_illegal ? S_HALT : S_EXEC_R;
                    OP_ADD, OP_SUB, OP_NAND, OP_OR: nxt = S_EXEC_R;
                    OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_NANDI, OP_ORI:
                                                  nxt = S_EXEC_I;
                    OP_LW, OP_SW:                 nxt = S_MEM_ADDR;
                    OP_BE, OP_BNE:                nxt = S_BRANCH;
                    OP_JMP:                       nxt = S_JUMP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MEM_ADDR:         nxt = (bus.OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:           nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:           nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_HALT:             nxt = S_HALT;
            default:            nxt = S_RST;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it;
    // OPCODE is stable from decode onward, so decoding it one cycle early is exact.
    always_comb begin
        ctrl_d = '0;
        unique case (nxt)
            S_FETCH: begin
                ctrl_d.fetch     = 1'b1;
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = SRCB_ONE;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b = SRCB_OFF;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REG;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_EXEC_I: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.ext_sel   = dec_ext_sel;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_ALU_WB: ctrl_d.reg_write = 1'b1;
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.ext_sel   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.ior_d     = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = SRCB_REG;
                ctrl_d.alu_op        = ALU_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_src        = PCSRC_ALUOUT;
                ctrl_d.branch_ne     = (bus.OPCODE == OP_BNE);
            end
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = PCSRC_JUMP;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RST;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_d;
            if (nxt == S_HALT)
                illegal_q <= 1'b1;
        end
    end

    // IR load and PC increment fire only on the fetch cycle where memory delivers.
    assign bus.C_IRWrite     = ctrl_q.fetch & bus.mem_ready;
    assign bus.C_PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
    assign bus.C_PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.C_BranchNe    = ctrl_q.branch_ne;
    assign bus.C_PCSrc       = ctrl_q.pc_src;
    assign bus.C_IorD        = ctrl_q.ior_d;
    assign bus.C_MemRead     = ctrl_q.mem_read;
    assign bus.C_MemWrite    = ctrl_q.mem_write;
    assign bus.C_RegWrite    = ctrl_q.reg_write;
    assign bus.C_MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.C_ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.C_ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.C_ExtSel      = ctrl_q.ext_sel;
    assign bus.C_ALUOp       = ctrl_q.alu_op;
    assign bus.C_Illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands
// each instruction into its expected per-cycle strobe pattern.
module tb_multicycle_control;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic       brne;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       m2r;
        logic       srca;
        logic [1:0] srcb;
        logic       ext;
        logic [3:0] aluop;
        logic       ill;
    } outs_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    logic model_ill;

    outs_t eq[$];
    logic  rq[$];
    string nq[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t s;
        s.irw   = bus.C_IRWrite;
        s.pcw   = bus.C_PCWrite;
        s.pcwc  = bus.C_PCWriteCond;
        s.brne  = bus.C_BranchNe;
        s.pcsrc = bus.C_PCSrc;
        s.iord  = bus.C_IorD;
        s.mrd   = bus.C_MemRead;
        s.mwr   = bus.C_MemWrite;
        s.rw    = bus.C_RegWrite;
        s.m2r   = bus.C_MemtoReg;
        s.srca  = bus.C_ALUSrcA;
        s.srcb  = bus.C_ALUSrcB;
        s.ext   = bus.C_ExtSel;
        s.aluop = bus.C_ALUOp;
        s.ill   = bus.C_Illegal;
        return s;
    endfunction

    // 0 R-type, 1 immediate, 2 lw, 3 sw, 4 branch, 5 jmp, 6 halt
    function automatic int kind_of(logic [3:0] op, logic [3:0] fn);
        case (op)
            4'b1000, 4'b1100, 4'b1011, 4'b1111:                   return 0;
            4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: return 1;
            4'b0001: return 2;
            4'b0010: return 3;
            4'b0100, 4'b0101: return 4;
            4'b0011: return 5;
            default: return (fn >= 4'd1 && fn <= 4'd3) ? 0 : 6;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [3:0] op, logic [3:0] fn);
        case (op)
            4'b1100, 4'b1101, 4'b1110: return 4'b0001;
            4'b1011, 4'b0111:          return 4'b0101;
            4'b1111, 4'b0110:          return 4'b0110;
            4'b0000: return (fn == 4'd1) ? 4'b0010 : (fn == 4'd2) ? 4'b0011 : 4'b0100;
            default:                   return 4'b0000;
        endcase
    endfunction

    task automatic push(input outs_t e, input logic r, input string nm);
        eq.push_back(e);
        rq.push_back(r);
        nq.push_back(nm);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int fw,
                             input int mw, input int max_steps, input string tag);
        outs_t z, e, act;
        logic  r;
        string nm;
        int    k;
        int    n;
        eq.delete(); rq.delete(); nq.delete();
        z = '0;
        z.ill = model_ill;
        k = kind_of(op, fn);
        e = z; e.mrd = 1'b1; e.srcb = 2'b01;
        for (int i = 0; i < fw; i++) push(e, 1'b0, "fetch_wait");
        e.irw = 1'b1; e.pcw = 1'b1;
        push(e, 1'b1, "fetch");
        e = z; e.srcb = 2'b11;
        push(e, 1'($urandom), "decode");
        case (k)
            0, 1: begin
                e = z; e.srca = 1'b1; e.aluop = alu_of(op, fn);
                e.srcb = (k == 0) ? 2'b00 : 2'b10;
                e.ext  = (k == 1) && (op == 4'b1001 || op == 4'b1101);
                push(e, 1'($urandom), "exec");
                e = z; e.rw = 1'b1;
                push(e, 1'($urandom), "alu_wb");
            end
            2, 3: begin
                e = z; e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
                push(e, 1'($urandom), "mem_addr");
                e = z; e.iord = 1'b1;
                if (k == 2) e.mrd = 1'b1; else e.mwr = 1'b1;
                for (int i = 0; i < mw; i++) push(e, 1'b0, "mem_wait");
                push(e, 1'b1, "mem_done");
                if (k == 2) begin
                    e = z; e.rw = 1'b1; e.m2r = 1'b1;
                    push(e, 1'($urandom), "mem_wb");
                end
            end
            4: begin
                e = z; e.srca = 1'b1; e.aluop = 4'b0001; e.pcwc = 1'b1;
                e.pcsrc = 2'b01; e.brne = (op == 4'b0101);
                push(e, 1'($urandom), "branch");
            end
            5: begin
                e = z; e.pcw = 1'b1; e.pcsrc = 2'b10;
                push(e, 1'($urandom), "jump");
            end
            default: begin
                model_ill = 1'b1;
                e = '0; e.ill = 1'b1;
                for (int i = 0; i < 6; i++) push(e, 1'($urandom), "halt");
            end
        endcase
        n = 0;
        while (eq.size() > 0 && n < max_steps) begin
            e  = eq.pop_front();
            r  = rq.pop_front();
            nm = nq.pop_front();
            @(posedge clk);
            #1;
            if (n == 0) begin
                bus.OPCODE    = op;
                bus.FUNCFIELD = fn;
            end
            bus.mem_ready = r;
            #1;
            act = sample();
            n_checks++;
            if (act !== e) begin
                n_fails++;
                $display("FAIL %s/%s op=%b fn=%b cycle %0d: got %h expected %h",
                         tag, nm, op, fn, n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_reset();
        outs_t act, e;
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_ill = 1'b0;
        act = sample();
        n_checks++;
        if (act !== outs_t'('0)) begin
            n_fails++;
            $display("FAIL reset_state: got %h expected 0", act);
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        act = sample();
        e = '0; e.mrd = 1'b1; e.srcb = 2'b01;
        n_checks++;
        if (act !== e) begin
            n_fails++;
            $display("FAIL reset_then_fetch: got %h expected %h", act, e);
        end
    endtask

    task automatic test_add();
        run_instr(4'b1000, 4'h0, 0, 0, 100, "add");
    endtask

    task automatic test_lw_wait();
        run_instr(4'b0001, 4'h5, 0, 2, 100, "lw_wait2");
        run_instr(4'b0010, 4'h0, 2, 1, 100, "sw_wait");
    endtask

    task automatic test_branches();
        run_instr(4'b0101, 4'h0, 0, 0, 100, "bne");
        run_instr(4'b0100, 4'h0, 1, 0, 100, "be");
        run_instr(4'b0011, 4'h0, 0, 0, 100, "jmp");
    endtask

    task automatic test_shift();
        run_instr(4'b0000, 4'b0011, 0, 0, 100, "sar");
        run_instr(4'b0000, 4'b0001, 0, 0, 100, "shl");
        run_instr(4'b1101, 4'b0000, 0, 0, 100, "subi");
    endtask

    task automatic test_random();
        logic [3:0] op, fn;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            fn = (op == 4'b0000) ? 4'($urandom_range(1, 3)) : 4'($urandom);
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 100, "rand");
        end
    endtask

    task automatic test_halt();
        run_instr(4'b0000, 4'b0111, 0, 0, 100, "halt");
        test_reset();
        run_instr(4'b1111, 4'h0, 0, 0, 100, "or_after_halt");
    endtask

    task automatic test_mid_store_reset();
        outs_t act;
        run_instr(4'b0010, 4'h0, 0, 3, 4, "sw_abort");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        act = sample();
        n_checks++;
        if (act !== outs_t'('0)) begin
            n_fails++;
            $display("FAIL mid_store_reset: got %h expected 0", act);
        end
        run_instr(4'b1010, 4'h0, 0, 0, 100, "addui_after_abort");
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_ill = 1'b0;
        rst = 1'b1;
        bus.OPCODE    = 4'h0;
        bus.FUNCFIELD = 4'h0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branches();
        test_shift();
        test_random();
        test_halt();
        test_mid_store_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing controller for the 16-bit processor. It steps every instruction through fetch, decode, execute, memory and write-back, and drives all datapath strobes: instruction-register load, PC update, memory access, ALU control and register-file write. It sits beside the instruction register and consumes that register's OPCODE and FUNCFIELD outputs. A memory ready handshake stretches fetch, load and store.

## Interface
- No parameters. State, opcode and ALU-op encodings are constants in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- OPCODE  in  4  instruction-register opcode field
- FUNCFIELD  in  4  instruction-register function field; meaningful only when OPCODE=0000
- mem_ready  in  1  memory has completed the current read or write this cycle
- C_IRWrite  out  1  load the instruction register
- C_PCWrite  out  1  unconditional PC write
- C_PCWriteCond  out  1  PC write if the branch condition holds
- C_BranchNe  out  1  0 = branch on zero, 1 = branch on not-zero
- C_PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- C_IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- C_MemRead  out  1  memory read strobe
- C_MemWrite  out  1  memory write strobe
- C_RegWrite  out  1  register-file write
- C_MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- C_ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- C_ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 1, 10 = extended immediate, 11 = branch offset
- C_ExtSel  out  1  immediate extension: 1 = sign, 0 = zero
- C_ALUOp  out  4  ALU operation: ADD 0000, SUB 0001, SHL 0010, SHR 0011, SAR 0100, NAND 0101, OR 0110
- C_Illegal  out  1  sticky flag: an undefined opcode/function was decoded

## Operation
- States:
  - S_RST
  - S_FETCH
  - S_DECODE
  - S_EXEC_R
  - S_EXEC_I
  - S_ALU_WB
  - S_MEM_ADDR
  - S_MEM_RD
  - S_MEM_WB
  - S_MEM_WR
  - S_BRANCH
  - S_JUMP
  - S_HALT
- Outputs are a Moore decode of the state. The only exceptions are C_IRWrite and C_PCWrite in S_FETCH, which are additionally gated by mem_ready.
- Every output not listed for a state is 0.
- S_RST: all outputs 0; next state is S_FETCH.
- S_FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=ADD; this precomputes the branch target into ALUOut.
  - Dispatch on OPCODE:
    - R-type (1000, 1100, 1011, 1111) and shifts (0000 with FUNCFIELD 0001/0010/0011) -> S_EXEC_R.
    - Immediates (1001, 1010, 1101, 1110, 0111, 0110) -> S_EXEC_I.
    - lw 0001 and sw 0010 -> S_MEM_ADDR.
    - be 0100 and bne 0101 -> S_BRANCH.
    - jmp 0011 -> S_JUMP.
    - Opcode 0000 with any other FUNCFIELD -> S_HALT.
- S_EXEC_R:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUOp: ADD for 1000, SUB for 1100, NAND for 1011, OR for 1111; SHL, SHR or SAR from FUNCFIELD 0001, 0010 or 0011.
  - Next state is S_ALU_WB.
- S_EXEC_I:
  - ALUSrcA=1, ALUSrcB=10.
  - ExtSel=1 for 1001 and 1101, 0 otherwise.
  - ALUOp: ADD for 1001/1010, SUB for 1101/1110, NAND for 0111, OR for 0110.
  - Next state is S_ALU_WB.
- S_ALU_WB: RegWrite=1, MemtoReg=0; next state is S_FETCH.
- S_MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtSel=1, ALUOp=ADD. Next state is S_MEM_RD for lw, S_MEM_WR for sw.
- S_MEM_RD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to S_MEM_WB.
- S_MEM_WB: RegWrite=1, MemtoReg=1; next state is S_FETCH.
- S_MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to S_FETCH.
- S_BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSrc=01.
  - BranchNe=1 for opcode 0101, 0 for 0100.
  - Next state is S_FETCH.
- S_JUMP: PCWrite=1, PCSrc=10; next state is S_FETCH.
- S_HALT: all strobes 0. C_Illegal is set and the FSM remains in S_HALT until rst.

## Timing
- Reset:
  - rst sampled high at a clock edge puts the FSM in S_RST and clears C_Illegal.
  - Reset mid-instruction aborts the instruction immediately: no further RegWrite, MemWrite or PC write.
  - rst held high keeps the FSM in S_RST.
- Instruction latency with mem_ready always 1:
  - R-type and immediate: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
  - jmp: 3 cycles.
- Each cycle of mem_ready=0 in S_FETCH, S_MEM_RD or S_MEM_WR adds exactly one cycle. Strobes stay asserted and stable throughout the wait.
- IRWrite and PCWrite pulse for exactly one cycle per instruction, on the cycle where mem_ready=1 in S_FETCH.
- OPCODE and FUNCFIELD are only sampled from S_DECODE onward. They are stable then because IRWrite is 0 outside S_FETCH.

## Structure
- Shared package (proc_pkg) holds:
  - opcode constants (OP_ADD 1000, OP_LW 0001, …);
  - function codes 0001/0010/0011;
  - ALUOp encodings;
  - the state enumeration;
  - PCSrc and ALUSrcB encodings.
- One natural sub-module: alu_op_decode, a combinational map from OPCODE/FUNCFIELD to ALUOp, ExtSel and an illegal flag. It is shared by S_EXEC_R, S_EXEC_I and S_DECODE.

## Test plan
- **Reset:** rst=1 for 2 cycles, then 0 -> all outputs 0 in S_RST; next cycle MemRead=1, IorD=0, ALUSrcB=01.
- **add:** OPCODE=1000, mem_ready=1 -> IRWrite on cycle 1; ALUOp=0000 with ALUSrcB=00 on cycle 3; RegWrite=1 with MemtoReg=0 on cycle 4; MemRead on cycle 5.
- **lw with 2 wait cycles:** OPCODE=0001, mem_ready low 2 cycles in S_MEM_RD -> MemRead=1, IorD=1 held 3 cycles; then RegWrite=1 with MemtoReg=1; total 7 cycles.
- **Branches:**
  - bne, OPCODE=0101 -> S_BRANCH shows PCWriteCond=1, BranchNe=1, ALUOp=0001, PCSrc=01.
  - be, OPCODE=0100 -> BranchNe=0.
- **Shift and illegal function:**
  - OPCODE=0000 with FUNCFIELD=0011 -> ALUOp=0100.
  - FUNCFIELD=0111 -> S_HALT; C_Illegal=1 held; no strobes until rst.
- **Mid-store reset:** sw, rst asserted while in S_MEM_WR with mem_ready=0 -> MemWrite=0 the next cycle; FSM in S_RST.
